counter_seq_ctrl: RTL and testbench
===================================

COUNTER_SEQ_CTRL -- requirements
Module: counter_seq_ctrl

Interface
REQ-001 Parameter DIV, default 4: prescale ratio, in clk cycles per count step; legal range 2..65535.
REQ-002 Parameter DIVW, default 16: prescaler counter width; DIV SHALL fit in DIVW bits.
REQ-003 clk  input  1  single system clock; all state SHALL update on its rising edge.
REQ-004 reset  input  1  asynchronous, active-high reset.
REQ-005 start  input  1  begin or resume counting.
REQ-006 stop  input  1  pause counting; value held.
REQ-007 clear  input  1  force count to 0 and return to IDLE.
REQ-008 load  input  1  load load_val into count.
REQ-009 load_val  input  4  value used by load.
REQ-010 oneshot  input  1  1: stop at limit; 0: wrap at limit.
REQ-011 limit  input  4  terminal count value.
REQ-012 count  output  4  current counter value, registered.
REQ-013 tick  output  1  one-cycle pulse, registered, on every count step.
REQ-014 busy  output  1  high in RUN, registered.
REQ-015 done  output  1  high while in DONE, registered.

Function
REQ-016 The block SHALL implement FSM states IDLE, RUN, PAUSE and DONE; the divided clock SHALL be a clock enable only, and the block SHALL NOT derive any clock.
REQ-017 Command priority on any edge SHALL be: clear > load > stop > start.
REQ-018 clear: count:=0, prescaler:=0, state:=IDLE, tick:=0, from any state.
REQ-019 load: count:=load_val and prescaler:=0; state unchanged, except DONE goes to IDLE.
REQ-020 Transitions on start: IDLE->RUN; PAUSE->RUN; DONE->RUN with count:=0. On stop: RUN->PAUSE. Start while in RUN SHALL be ignored.
REQ-021 In RUN, the prescaler SHALL increment each cycle; when it equals DIV-1 it SHALL reset to 0, tick SHALL be 1 for that cycle, and count SHALL step on the same edge.
REQ-022 After start is sampled at edge N, the first tick and count step SHALL occur at edge N+DIV.
REQ-023 Step rule: if count==limit, then with oneshot=1 state:=DONE and count is held; with oneshot=0 count:=0. Otherwise count:=count+1, modulo 16.
REQ-024 With oneshot=0 and limit=15, the counter SHALL wrap 15->0.
REQ-025 If count>limit because of a load, the counter SHALL count up to 15, wrap to 0, and then obey the limit.
REQ-026 In PAUSE, IDLE and DONE, the prescaler and count SHALL hold, and tick SHALL be 0.
REQ-027 stop and a terminal step on the same edge: stop SHALL win (PAUSE), the step SHALL NOT occur, and the prescaler SHALL hold.
REQ-028 Changes to limit or oneshot SHALL take effect at the next step.

Reset
REQ-029 While reset=1, asynchronously: count=0, prescaler=0, state=IDLE, tick=0, busy=0, done=0.
REQ-030 Reset asserted mid-count SHALL discard all progress; after release the block SHALL wait in IDLE for start.
REQ-031 Commands present during reset SHALL be ignored; the first sampling of commands SHALL be at the first edge after release.

Configuration
REQ-032 Macro COUNTER_SEQ_DOWN_EN: when defined, add port dir (input, 1 bit, 1 = count down).
REQ-033 With COUNTER_SEQ_DOWN_EN defined and dir=1, the step rule SHALL be:
  - count==limit: DONE (oneshot=1) or count:=15 (oneshot=0);
  - otherwise count:=count-1, modulo 16.
REQ-034 Without COUNTER_SEQ_DOWN_EN, the dir port SHALL NOT exist and the block SHALL count up only.

Verification
REQ-035 DIV=4, limit=5, oneshot=0, start at edge 0 -> tick at edges 4, 8, 12, …; count 1,2,3,4,5,0,1; busy=1 throughout.
REQ-036 oneshot=1, limit=3 -> count 1,2,3, then DONE at the 4th tick with done=1, count=3, busy=0; a later start -> count=0, state RUN.
REQ-037 RUN with count=2, stop pulse -> count and prescaler hold for 10 cycles; start -> the next tick arrives after the remaining prescaler cycles.
REQ-038 clear and load (load_val=9) on the same edge in RUN -> count=0, state IDLE; load alone -> count=9 and counting continues.
REQ-039 Reset asserted asynchronously mid-cycle at count=7 -> all outputs 0 immediately; after release, no tick until start.
REQ-040 COUNTER_SEQ_DOWN_EN, dir=1, load 2, limit=0, oneshot=0 -> count 2,1,0,15,14.

Source files
------------

// File: rtl/counter_seq_ctrl_if.sv
// Command/status bundle for counter_seq_ctrl; the controller takes the slave side.
// The dir signal exists only when COUNTER_SEQ_DOWN_EN is defined.
interface counter_seq_ctrl_if;
    logic       start;
    logic       stop;
    logic       clear;
    logic       load;
    logic [3:0] load_val;
    logic       oneshot;
    logic [3:0] limit;
`ifdef COUNTER_SEQ_DOWN_EN
    logic       dir;
`endif
    logic [3:0] count;
    logic       tick;
    logic       busy;
    logic       done;

    modport master (
        output start, stop, clear, load, load_val, oneshot, limit,
`ifdef COUNTER_SEQ_DOWN_EN
        output dir,
`endif
        input  count, tick, busy, done
    );

    modport slave (
        input  start, stop, clear, load, load_val, oneshot, limit,
`ifdef COUNTER_SEQ_DOWN_EN
        input  dir,
`endif
        output count, tick, busy, done
    );
endinterface

// File: rtl/counter_seq_ctrl.sv
// Prescaled 4-bit sequence counter with IDLE/RUN/PAUSE/DONE control.
// Define COUNTER_SEQ_DOWN_EN to add the dir input (1 = count down).
module counter_seq_ctrl #(
    parameter int unsigned DIV  = 4,
    parameter int unsigned DIVW = 16
) (
    input logic               clk,
    input logic               reset,
    counter_seq_ctrl_if.slave bus
);
    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] RUN   = 2'd1;
    localparam logic [1:0] PAUSE = 2'd2;
    localparam logic [1:0] DONE  = 2'd3;

    localparam logic [DIVW-1:0] PRESC_LAST = DIVW'(DIV - 1);

    logic [1:0]      state, state_nx;
    logic [DIVW-1:0] presc, presc_nx;
    logic [3:0]      count, count_nx;
    logic            tick_nx;
    logic            tick_q, busy_q, done_q;
    logic            down;

`ifdef COUNTER_SEQ_DOWN_EN
    assign down = bus.dir;
`else
    assign down = 1'b0;
`endif

    // Commands are decoded in strict priority: clear, load, stop, start.
    always_comb begin
        // NOTE: every output of this block gets a default first so no path leaves it unassigned (no latch).
        state_nx = state;
        presc_nx = presc;
        count_nx = count;
        tick_nx  = 1'b0;

        if (bus.clear) begin
            state_nx = IDLE;
            presc_nx = '0;
            count_nx = '0;
        end else if (bus.load) begin
            count_nx = bus.load_val;
            presc_nx = '0;
            if (state == DONE)
                state_nx = IDLE;
        end else if (bus.stop) begin
            if (state == RUN)
                state_nx = PAUSE;
        end else if (bus.start && state != RUN) begin
            state_nx = RUN;
            if (state == DONE)
                count_nx = '0;
        end else if (state == RUN) begin
            if (presc == PRESC_LAST) begin
                presc_nx = '0;
                tick_nx  = 1'b1;
                if (count == bus.limit) begin
                    if (bus.oneshot)
                        state_nx = DONE;
                    else
                        count_nx = down ? 4'd15 : 4'd0;
                end else begin
                    count_nx = down ? count - 4'd1 : count + 4'd1;
                end
            end else begin
                presc_nx = presc + DIVW'(1);
            end
        end
    end

    // busy/done follow the next state so they line up with the state register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state  <= IDLE;
            presc  <= '0;
            count  <= '0;
            tick_q <= 1'b0;
            busy_q <= 1'b0;
            done_q <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments here so every register samples pre-edge values.
            state  <= state_nx;
            presc  <= presc_nx;
            count  <= count_nx;
            tick_q <= tick_nx;
            busy_q <= (state_nx == RUN);
            done_q <= (state_nx == DONE);
        end
    end

    assign bus.count = count;
    assign bus.tick  = tick_q;
    assign bus.busy  = busy_q;
    assign bus.done  = done_q;
endmodule

// File: tb/tb_counter_seq_ctrl.sv
// Directed and randomized bench for counter_seq_ctrl against a cycle-level behavioural model.
module tb_counter_seq_ctrl;
    localparam int TB_DIV = 4;

    logic clk = 1'b0;
    logic reset;
    logic dir_val = 1'b0;

    counter_seq_ctrl_if bus ();

    counter_seq_ctrl #(.DIV(TB_DIV), .DIVW(16)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

`ifdef COUNTER_SEQ_DOWN_EN
    assign bus.dir = dir_val;
`endif

    always #5 clk = ~clk;

    typedef enum int {M_IDLE, M_RUN, M_PAUSE, M_DONE} mode_t;

    mode_t m_mode;
    int    m_count;
    int    m_elapsed;
    bit    m_tick;
    int    vectors     = 0;
    int    miscompares = 0;

    task automatic check(input string tag, input logic [3:0] obs, input logic [3:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_mode    = M_IDLE;
        m_count   = 0;
        m_elapsed = 0;
        m_tick    = 1'b0;
    endtask

    // One clock edge of the reference behaviour, using the commands applied at that edge.
    task automatic model_edge();
        m_tick = 1'b0;
        if (bus.clear) begin
            model_reset();
        end else if (bus.load) begin
            m_count   = int'(bus.load_val);
            m_elapsed = 0;
            if (m_mode == M_DONE) m_mode = M_IDLE;
        end else if (bus.stop) begin
            if (m_mode == M_RUN) m_mode = M_PAUSE;
        end else if (bus.start && m_mode != M_RUN) begin
            if (m_mode == M_DONE) m_count = 0;
            m_mode = M_RUN;
        end else if (m_mode == M_RUN) begin
            m_elapsed++;
            if (m_elapsed == TB_DIV) begin
                m_elapsed = 0;
                m_tick    = 1'b1;
                if (m_count == int'(bus.limit)) begin
                    if (bus.oneshot) m_mode = M_DONE;
                    else             m_count = dir_val ? 15 : 0;
                end else begin
                    m_count = dir_val ? (m_count + 15) % 16 : (m_count + 1) % 16;
                end
            end
        end
    endtask

    task automatic check_model(input string tag);
        check({tag, ".count"}, bus.count, 4'(m_count));
        check({tag, ".tick"},  4'(bus.tick), 4'(m_tick));
        check({tag, ".busy"},  4'(bus.busy), 4'(m_mode == M_RUN));
        check({tag, ".done"},  4'(bus.done), 4'(m_mode == M_DONE));
    endtask

    task automatic step(input string tag);
        @(posedge clk);
        if (reset) model_reset();
        else       model_edge();
        #1;
        check_model(tag);
    endtask

    task automatic run(input int n, input string tag);
        for (int i = 0; i < n; i++) step(tag);
    endtask

    task automatic idle_cmds();
        bus.start = 1'b0;
        bus.stop  = 1'b0;
        bus.clear = 1'b0;
        bus.load  = 1'b0;
    endtask

    initial begin
        int seq035 [7] = '{1, 2, 3, 4, 5, 0, 1};

        reset        = 1'b1;
        idle_cmds();
        bus.load_val = 4'd0;
        bus.limit    = 4'd5;
        bus.oneshot  = 1'b0;
        bus.start    = 1'b1;
        bus.load     = 1'b1;
        bus.load_val = 4'd9;
        model_reset();
        #1;
        check_model("reset_state");
        run(3, "cmds_in_reset");

        idle_cmds();
        reset = 1'b0;
        run(3, "post_release_idle");

        // Free-running wrap at limit 5.
        bus.start = 1'b1;
        step("start035");
        bus.start = 1'b0;
        for (int k = 1; k <= 28; k++) begin
            step("run035");
            check("seq035.tick", 4'(bus.tick), 4'(k % TB_DIV == 0));
            check("seq035.count", bus.count, (k < TB_DIV) ? 4'd0 : 4'(seq035[k / TB_DIV - 1]));
            check("seq035.busy", 4'(bus.busy), 4'd1);
        end

        // One-shot to limit 3, then restart from DONE.
        bus.clear = 1'b1;
        step("clear036");
        bus.clear   = 1'b0;
        bus.limit   = 4'd3;
        bus.oneshot = 1'b1;
        bus.start   = 1'b1;
        step("start036");
        bus.start = 1'b0;
        run(16, "run036");
        check("done036.count", bus.count, 4'd3);
        check("done036.done", 4'(bus.done), 4'd1);
        check("done036.busy", 4'(bus.busy), 4'd0);
        run(5, "hold036");
        bus.start = 1'b1;
        step("restart036");
        bus.start = 1'b0;
        check("restart036.count", bus.count, 4'd0);
        check("restart036.busy", 4'(bus.busy), 4'd1);

        // Pause mid-prescale, then resume with the remaining cycles.
        bus.clear = 1'b1;
        step("clear037");
        bus.clear   = 1'b0;
        bus.limit   = 4'd15;
        bus.oneshot = 1'b0;
        bus.start   = 1'b1;
        step("start037");
        bus.start = 1'b0;
        run(10, "run037");
        bus.stop = 1'b1;
        step("stop037");
        bus.stop = 1'b0;
        for (int k = 0; k < 10; k++) begin
            step("pause037");
            check("pause037.count", bus.count, 4'd2);
            check("pause037.tick", 4'(bus.tick), 4'd0);
        end
        bus.start = 1'b1;
        step("resume037");
        bus.start = 1'b0;
        step("resume037_a");
        check("resume037_a.tick", 4'(bus.tick), 4'd0);
        step("resume037_b");
        check("resume037_b.tick", 4'(bus.tick), 4'd1);
        check("resume037_b.count", bus.count, 4'd3);

        // Stop on the same edge as a pending step: stop wins, prescaler holds.
        run(3, "pre_stop027");
        bus.stop = 1'b1;
        step("stop027");
        bus.stop = 1'b0;
        check("stop027.count", bus.count, 4'd3);
        check("stop027.tick", 4'(bus.tick), 4'd0);
        bus.start = 1'b1;
        step("start027");
        bus.start = 1'b0;
        step("step027");
        check("step027.tick", 4'(bus.tick), 4'd1);
        check("step027.count", bus.count, 4'd4);

        // clear beats load; load alone keeps running.
        bus.clear    = 1'b1;
        bus.load     = 1'b1;
        bus.load_val = 4'd9;
        step("clrld038");
        idle_cmds();
        check("clrld038.count", bus.count, 4'd0);
        check("clrld038.busy", 4'(bus.busy), 4'd0);
        run(4, "idle038");
        bus.start = 1'b1;
        step("start038");
        bus.start = 1'b0;
        run(2, "run038");
        bus.load = 1'b1;
        step("load038");
        bus.load = 1'b0;
        check("load038.count", bus.count, 4'd9);
        check("load038.busy", 4'(bus.busy), 4'd1);
        run(3, "after_load038");
        step("tick038");
        check("tick038.count", bus.count, 4'd10);

        // Loaded above limit: run up through 15, wrap, then obey limit.
        bus.limit = 4'd5;
        run(24, "above025");
        check("wrap025.count", bus.count, 4'd0);
        run(24, "limit025");
        check("limit025.count", bus.count, 4'd0);

        // limit 15 wraps 15 -> 0.
        bus.limit    = 4'd15;
        bus.load     = 1'b1;
        bus.load_val = 4'd14;
        step("load024");
        bus.load = 1'b0;
        run(4, "run024");
        check("at15_024.count", bus.count, 4'd15);
        run(4, "run024b");
        check("wrap024.count", bus.count, 4'd0);

        // Asynchronous reset mid-cycle at count 7.
        bus.load_val = 4'd7;
        bus.load     = 1'b1;
        step("load039");
        bus.load = 1'b0;
        run(2, "run039");
        check("pre039.count", bus.count, 4'd7);
        #2;
        reset = 1'b1;
        #1;
        model_reset();
        check_model("async039");
        #3;
        reset = 1'b0;
        for (int k = 0; k < 10; k++) begin
            step("idle039");
            check("idle039.tick", 4'(bus.tick), 4'd0);
        end

`ifdef COUNTER_SEQ_DOWN_EN
        // Down count wraps 0 -> 15 with limit 0.
        dir_val      = 1'b1;
        bus.load_val = 4'd2;
        bus.load     = 1'b1;
        step("load040");
        bus.load    = 1'b0;
        bus.limit   = 4'd0;
        bus.oneshot = 1'b0;
        bus.start   = 1'b1;
        step("start040");
        bus.start = 1'b0;
        run(12, "run040");
        check("wrap040.count", bus.count, 4'd15);
        run(4, "run040b");
        check("end040.count", bus.count, 4'd14);
        bus.clear = 1'b1;
        step("clear040");
        bus.clear = 1'b0;
`endif

        // Randomized command mix, including limit/oneshot changes and rare resets.
        for (int k = 0; k < 3000; k++) begin
            bus.clear    = ($urandom_range(0, 99) < 2);
            bus.load     = ($urandom_range(0, 99) < 4);
            bus.stop     = ($urandom_range(0, 99) < 6);
            bus.start    = ($urandom_range(0, 99) < 20);
            bus.load_val = 4'($urandom_range(0, 15));
            if ($urandom_range(0, 31) == 0) bus.limit   = 4'($urandom_range(0, 15));
            if ($urandom_range(0, 31) == 0) bus.oneshot = 1'($urandom_range(0, 1));
`ifdef COUNTER_SEQ_DOWN_EN
            if ($urandom_range(0, 63) == 0) dir_val = 1'($urandom_range(0, 1));
`endif
            if ($urandom_range(0, 499) == 0) begin
                #2;
                reset = 1'b1;
                #1;
                model_reset();
                check_model("rand_async_rst");
                #2;
                reset = 1'b0;
            end
            step("random");
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
